keypad_time_loader: RTL and testbench
=====================================

# keypad_time_loader

Consumes the debounced digit strobe and BCD digit produced by the keypad encoder, and assembles them into the microwave's four-digit MM:SS cook time. On start it counts that time down once per second, and it emits a single-cycle `fim` pulse at 00:00. It sits between the keypad encoder and the display/magnetron control in the microwave top level.

## Interface
- `TICK_DIV`, default 100: clock cycles per one-second tick (100 Hz system clock).
- `Clock`  in  1  system clock; all logic is on the rising edge.
- `Clear`  in  1  synchronous active-high reset; highest priority.
- `digito`  in  4  BCD digit from the encoder; valid while `digito_valido` is high.
- `digito_valido`  in  1  debounced key strobe from the encoder; may last one or more cycles.
- `iniciar`  in  1  start/resume request, level-sampled each cycle.
- `pausar`  in  1  pause/cancel request, level-sampled each cycle.
- `mm_dez`, `mm_uni`, `ss_dez`, `ss_uni`  out  4 each  BCD time digits, registered.
- `ativo`  out  1  high while in CONTANDO, registered.
- `fim`  out  1  one-cycle pulse when the countdown reaches 00:00.

## Operation
- States: IDLE, CONTANDO, PAUSADO. After `Clear`: IDLE, all four digits 0, `ativo`=0, `fim`=0, prescaler 0, strobe history 0.
- Strobe edge detect:
  - Internal register holds the previous `digito_valido`.
  - A keypress is `digito_valido`=1 with previous=0.
  - A held strobe counts once.
  - The history register updates in every state.
- IDLE, keypress with `digito` ≤ 9:
  - Shift left: `mm_dez`←`mm_uni`, `mm_uni`←`ss_dez`, `ss_dez`←`ss_uni`, `ss_uni`←`digito`.
  - The old `mm_dez` is discarded.
  - `digito` > 9 is ignored.
- IDLE, `iniciar`=1:
  - If the time ≠ 0000: go to CONTANDO, prescaler←0.
  - If the time = 0000: stay in IDLE, no `fim`.
- IDLE, `pausar`=1: all digits←0.
- CONTANDO:
  - Prescaler increments each cycle and wraps at `TICK_DIV`−1.
  - On the wrap cycle, time decrements by one second.
- CONTANDO, `pausar`=1: go to PAUSADO. The prescaler holds its value.
- PAUSADO:
  - `iniciar`=1 → CONTANDO; the prescaler resumes from its held value.
  - `pausar`=1 → IDLE, digits←0 (cancel).
- Keypresses in CONTANDO and PAUSADO are ignored.
- Priority: `Clear` > `pausar` > `iniciar` > keypress. With `iniciar` and `pausar` both high, `pausar` acts.
- Decrement rule (BCD borrow):
  - `ss_uni`>0 → `ss_uni`−1.
  - Else `ss_uni`←9; if `ss_dez`>0 → `ss_dez`−1.
  - Else `ss_dez`←5; if `mm_uni`>0 → `mm_uni`−1.
  - Else `mm_uni`←9, `mm_dez`−1.
- Entered seconds tens digits above 5 are not normalised. Example: 00:75 counts 75…00, then borrows into minutes as usual.
- When a decrement yields 0000:
  - On that same edge: `fim`←1 for exactly one cycle, state→IDLE, `ativo`←0.
  - Digits stay 0000 and new entry is allowed immediately.
- The decrement never wraps below 0000.

## Timing
- Keypress latency: `digito_valido` rises before edge k; the shifted digits are visible after edge k.
- Start latency:
  - `iniciar` sampled at edge k → `ativo`=1 after edge k.
  - First decrement at edge k+`TICK_DIV`.
  - Then one decrement every `TICK_DIV` cycles.
- Runtime: a start from time T seconds gives `fim` after edge k+T·`TICK_DIV`.
- Pause/resume: pause and resume preserve the partial second, so total CONTANDO cycles equal T·`TICK_DIV`.
- `Clear` mid-countdown: all outputs 0 on that edge and no `fim` pulse.

## Test plan
- `Clear`, then keypresses 1,3,0 with each strobe held 3 cycles → digits 0,1,3,0 (01:30). Held strobe shifts once only.
- Keypresses 5,7,2,4,9 → 7,2,4,9 (oldest digit dropped). Strobe with `digito`=12 → no change.
- Enter 0,0,0,2, `iniciar`, `TICK_DIV`=4:
  - 00:01 after edge k+4.
  - 00:00 with `fim`=1 for one cycle at edge k+8.
  - `ativo` high for edges k..k+7, then IDLE.
- Borrow chain, `TICK_DIV`=2: 10:00 counts to 09:59 after 2 cycles. 01:00 → 00:59.
- Pause after 1.5 s with `TICK_DIV`=4 (00:05 start): `pausar` for 10 cycles holds 00:04. Resume → 00:03 after 2 more cycles. A second `pausar` in PAUSADO → 00:00, IDLE, no `fim`.
- Corner cases:
  - `iniciar` with time 0000 → stays IDLE, `fim` never asserts.
  - `iniciar`+`pausar` together in CONTANDO → PAUSADO.
  - `Clear` mid-count → all outputs 0, no `fim`.

Source files
------------

// File: rtl/keypad_time_loader.sv
// Assembles keypad digits into an MM:SS cook time and counts it down once per
// TICK_DIV cycles, pulsing fim when the countdown reaches 00:00.
module keypad_time_loader #(
  parameter int TICK_DIV = 100
) (
  input  logic       Clock,
  input  logic       Clear,
  input  logic [3:0] digito,
  input  logic       digito_valido,
  input  logic       iniciar,
  input  logic       pausar,
  output logic [3:0] mm_dez,
  output logic [3:0] mm_uni,
  output logic [3:0] ss_dez,
  output logic [3:0] ss_uni,
  output logic       ativo,
  output logic       fim
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, CONTANDO, PAUSADO} state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic          valid_prev_reg;
  logic [3:0]    md_reg, mu_reg, sd_reg, su_reg;
  logic [3:0]    md_next, mu_next, sd_next, su_next;
  logic          ativo_reg, ativo_next;
  logic          fim_reg, fim_next;

  logic [3:0]    dec_md, dec_mu, dec_sd, dec_su;
  logic          keypress, time_zero, dec_zero;

  assign keypress  = digito_valido && !valid_prev_reg;
  assign time_zero = ({md_reg, mu_reg, sd_reg, su_reg} == 16'd0);

  // One-second BCD decrement; seconds tens borrow reloads 5, units reload 9.
  always_comb begin
    dec_md = md_reg;
    dec_mu = mu_reg;
    dec_sd = sd_reg;
    dec_su = su_reg;
    if (su_reg != 4'd0) begin
      dec_su = su_reg - 4'd1;
    end else begin
      dec_su = 4'd9;
      if (sd_reg != 4'd0) begin
        dec_sd = sd_reg - 4'd1;
      end else begin
        dec_sd = 4'd5;
        if (mu_reg != 4'd0) begin
          dec_mu = mu_reg - 4'd1;
        end else begin
          dec_mu = 4'd9;
          dec_md = md_reg - 4'd1;
        end
      end
    end
  end

  assign dec_zero = ({dec_md, dec_mu, dec_sd, dec_su} == 16'd0);

  always_comb begin
    state_next = state_reg;
    presc_next = presc_reg;
    md_next    = md_reg;
    mu_next    = mu_reg;
    sd_next    = sd_reg;
    su_next    = su_reg;
    fim_next   = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (pausar) begin
          md_next = 4'd0;
          mu_next = 4'd0;
          sd_next = 4'd0;
          su_next = 4'd0;
        end else if (iniciar) begin
          if (!time_zero) begin
            state_next = CONTANDO;
            presc_next = '0;
          end
        end else if (keypress && (digito <= 4'd9)) begin
          md_next = mu_reg;
          mu_next = sd_reg;
          sd_next = su_reg;
          su_next = digito;
        end
      end
      CONTANDO: begin
        // Pausing freezes the prescaler so the partial second survives resume.
        if (pausar) begin
          state_next = PAUSADO;
        end else if (presc_reg == PRESC_LAST) begin
          presc_next = '0;
          md_next    = dec_md;
          mu_next    = dec_mu;
          sd_next    = dec_sd;
          su_next    = dec_su;
          if (dec_zero) begin
            fim_next   = 1'b1;
            state_next = IDLE;
          end
        end else begin
          presc_next = presc_reg + PW'(1);
        end
      end
      PAUSADO: begin
        if (pausar) begin
          state_next = IDLE;
          md_next    = 4'd0;
          mu_next    = 4'd0;
          sd_next    = 4'd0;
          su_next    = 4'd0;
        end else if (iniciar) begin
          state_next = CONTANDO;
        end
      end
      default: state_next = IDLE;
    endcase
    ativo_next = (state_next == CONTANDO);
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      state_reg      <= IDLE;
      presc_reg      <= '0;
      valid_prev_reg <= 1'b0;
      md_reg         <= 4'd0;
      mu_reg         <= 4'd0;
      sd_reg         <= 4'd0;
      su_reg         <= 4'd0;
      ativo_reg      <= 1'b0;
      fim_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      presc_reg      <= presc_next;
      valid_prev_reg <= digito_valido;
      md_reg         <= md_next;
      mu_reg         <= mu_next;
      sd_reg         <= sd_next;
      su_reg         <= su_next;
      ativo_reg      <= ativo_next;
      fim_reg        <= fim_next;
    end
  end

  assign mm_dez = md_reg;
  assign mm_uni = mu_reg;
  assign ss_dez = sd_reg;
  assign ss_uni = su_reg;
  assign ativo  = ativo_reg;
  assign fim    = fim_reg;

endmodule

// File: tb/tb_keypad_time_loader.sv
// Scoreboarded bench: a seconds-level reference model queues the expected
// post-edge outputs, and a negedge monitor compares them against the DUT.
module tb_keypad_time_loader;

  localparam int TD = 4;

  logic       Clock;
  logic       Clear;
  logic [3:0] digito;
  logic       digito_valido;
  logic       iniciar;
  logic       pausar;
  logic [3:0] mm_dez, mm_uni, ss_dez, ss_uni;
  logic       ativo, fim;

  keypad_time_loader #(.TICK_DIV(TD)) dut (
    .Clock(Clock), .Clear(Clear), .digito(digito), .digito_valido(digito_valido),
    .iniciar(iniciar), .pausar(pausar), .mm_dez(mm_dez), .mm_uni(mm_uni),
    .ss_dez(ss_dez), .ss_uni(ss_uni), .ativo(ativo), .fim(fim)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [3:0] md, mu, sd, su;
    logic       ativo, fim;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   dut_fims = 0;
  bit   done    = 1'b0;

  // Reference model: time held as minutes and seconds integers (seconds may
  // exceed 59 when entered that way); mode 0=idle, 1=counting, 2=paused.
  int m_mm = 0, m_ss = 0, m_pre = 0, m_mode = 0, m_fims = 0;
  bit m_prev = 0, m_started = 0, m_fim = 0;

  always @(posedge Clock) begin
    if (!done) begin
      int t;
      m_fim = 0;
      if (Clear) begin
        m_mm = 0; m_ss = 0; m_pre = 0; m_mode = 0; m_prev = 0;
        m_started = 1;
      end else begin
        case (m_mode)
          0: begin
            if (pausar) begin
              m_mm = 0; m_ss = 0;
            end else if (iniciar) begin
              if (m_mm * 100 + m_ss != 0) begin
                m_mode = 1; m_pre = 0;
              end
            end else if (digito_valido && !m_prev && digito <= 9) begin
              t = ((m_mm * 100 + m_ss) * 10 + int'(digito)) % 10000;
              m_mm = t / 100; m_ss = t % 100;
            end
          end
          1: begin
            if (pausar) m_mode = 2;
            else begin
              m_pre = m_pre + 1;
              if (m_pre == TD) begin
                m_pre = 0;
                if (m_ss > 0) m_ss = m_ss - 1;
                else begin m_ss = 59; m_mm = m_mm - 1; end
                if (m_mm == 0 && m_ss == 0) begin
                  m_fim = 1; m_mode = 0; m_fims++;
                end
              end
            end
          end
          default: begin
            if (pausar) begin m_mode = 0; m_mm = 0; m_ss = 0; end
            else if (iniciar) m_mode = 1;
          end
        endcase
        m_prev = digito_valido;
      end
      if (m_started) begin
        exp_t e;
        e.md = 4'(m_mm / 10); e.mu = 4'(m_mm % 10);
        e.sd = 4'(m_ss / 10); e.su = 4'(m_ss % 10);
        e.ativo = (m_mode == 1); e.fim = m_fim;
        exp_q.push_back(e);
      end
    end
  end

  always @(negedge Clock) begin
    cyc++;
    if (exp_q.size() > 0) begin
      exp_t e, g;
      e = exp_q.pop_front();
      g = {mm_dez, mm_uni, ss_dez, ss_uni, ativo, fim};
      if (fim === 1'b1) dut_fims++;
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL outputs cyc=%0d got %h%h:%h%h ativo=%b fim=%b expected %h%h:%h%h ativo=%b fim=%b",
                 cyc, g.md, g.mu, g.sd, g.su, g.ativo, g.fim,
                 e.md, e.mu, e.sd, e.su, e.ativo, e.fim);
      end else begin
        $display("[TB] cyc=%0d %h%h:%h%h ativo=%b fim=%b ok", cyc, g.md, g.mu, g.sd, g.su, g.ativo, g.fim);
      end
    end
  end

  task automatic drive(input bit c, input bit v, input logic [3:0] d,
                       input bit i, input bit p, input int n);
    for (int k = 0; k < n; k++) begin
      Clear = c; digito_valido = v; digito = d; iniciar = i; pausar = p;
      @(negedge Clock);
    end
  endtask

  task automatic key(input logic [3:0] d);
    drive(0, 1, d, 0, 0, 3);
    drive(0, 0, d, 0, 0, 1);
  endtask

  task automatic enter4(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d);
    key(a); key(b); key(c); key(d);
  endtask

  initial begin
    bit v;
    int hold;
    logic [3:0] d;
    drive(1, 0, 0, 0, 0, 2);
    drive(0, 0, 0, 0, 0, 2);
    key(1); key(3); key(0);                       // 01:30
    key(5); key(7); key(2); key(4); key(9);       // 72:49
    key(4'd12);                                   // ignored
    drive(0, 0, 0, 0, 1, 1);                      // clear digits
    enter4(0, 0, 0, 2);
    drive(0, 0, 0, 1, 0, 1);
    drive(0, 0, 0, 0, 0, 12);                     // runs out with fim
    enter4(1, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 1);
    drive(0, 0, 0, 0, 0, 5);                      // 09:59
    drive(0, 0, 0, 0, 1, 2);                      // pause, cancel
    enter4(0, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 1);
    drive(0, 0, 0, 0, 0, 5);                      // 00:59
    drive(0, 0, 0, 0, 1, 2);
    enter4(0, 0, 0, 5);
    drive(0, 0, 0, 1, 0, 1);
    drive(0, 0, 0, 0, 0, 6);
    drive(0, 0, 0, 0, 1, 1);                      // paused at 00:04
    drive(0, 0, 0, 0, 0, 10);
    key(8);                                       // ignored while paused
    drive(0, 0, 0, 1, 0, 1);
    drive(0, 0, 0, 0, 0, 3);                      // 00:03
    drive(0, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 1, 1);                      // cancel, no fim
    drive(0, 0, 0, 1, 0, 6);                      // start at 0000
    enter4(0, 0, 7, 5);
    drive(0, 0, 0, 1, 0, 1);
    drive(0, 0, 0, 0, 0, 3);
    drive(0, 0, 0, 1, 1, 1);                      // both -> paused
    drive(0, 0, 0, 0, 0, 3);
    drive(0, 0, 0, 1, 0, 1);
    drive(0, 0, 0, 0, 0, 7);
    drive(1, 0, 0, 0, 0, 1);                      // Clear mid-count
    drive(0, 0, 0, 0, 0, 3);
    enter4(0, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 1);
    drive(0, 0, 0, 0, 0, 60 * TD + 4);            // full minute to fim
    v = 0; hold = 0; d = 0;
    for (int n = 0; n < 4000; n++) begin
      if (hold > 0) hold--;
      else begin
        v = ($urandom_range(0, 1) == 1);
        d = 4'($urandom_range(0, 15));
        hold = $urandom_range(0, 3);
      end
      drive(($urandom_range(0, 599) == 0), v, d,
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 79) == 0), 1);
    end
    done = 1'b1;
    @(negedge Clock);
    @(negedge Clock);
    n_tests++;
    if (dut_fims != m_fims) begin
      n_fail++;
      $display("FAIL fim_count got %0d pulses expected %0d", dut_fims, m_fims);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
